// File: rtl/sdram_pkg.sv
// -----------------------------------------------------------------------------
// sdram_pkg
// Shared definitions for the SDRAM controller blocks: the command encodings
// driven on {cs_n, ras_n, cas_n, we_n}, the power-up init FSM state type, and
// the default device timing constants for the 133.33 MHz controller clock.
// No ports (package).
// -----------------------------------------------------------------------------
package sdram_pkg;

    // Command encodings, {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_INHIBIT   = 4'b1111;
    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_REFRESH   = 4'b0001;
    localparam logic [3:0] CMD_LMR       = 4'b0000;

    // Power-up initialization FSM states
    typedef enum logic [3:0] {
        ST_WAIT_LOCK,
        ST_POWERUP,
        ST_PRECHARGE,
        ST_WAIT_RP,
        ST_REFRESH,
        ST_WAIT_RFC,
        ST_LOAD_MODE,
        ST_WAIT_MRD,
        ST_DONE
    } init_state_t;

    // Default timing at 133.33 MHz (7.5 ns period)
    localparam int          DEF_T_POWERUP_CYC = 26667;  // 200 us
    localparam int          DEF_T_RP_CYC      = 3;
    localparam int          DEF_T_RFC_CYC     = 9;
    localparam int          DEF_T_MRD_CYC     = 2;
    localparam int          DEF_N_REFRESH     = 8;
    localparam logic [12:0] DEF_MODE_REG      = 13'h0032; // CL3, sequential, BL4

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Generic two-flop level synchronizer for slow, level-type signals crossing
// into the clk domain. Both flops clear to 0 on reset.
// Ports:
//   clk    in  1      destination clock
//   rst_n  in  1      asynchronous active-low reset
//   d      in  WIDTH  asynchronous input level
//   q      out WIDTH  synchronized level (2 clk latency)
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sdram_init_seq.sv
// -----------------------------------------------------------------------------
// sdram_init_seq
// SDRAM power-up initialization sequencer. After PLL lock it holds CKE high
// with NOPs for the power-up interval, then issues PRECHARGE ALL, N_REFRESH
// AUTO REFRESH commands and LOAD MODE REGISTER with exact spacing, and finally
// raises init_done to hand the bus to the command arbiter. Loss of PLL lock at
// any point drops CKE and restarts the full sequence once lock returns.
// Ports:
//   clk         in  1       controller clock
//   rst_n       in  1       asynchronous active-low reset
//   pll_lock    in  1       PLL lock, asynchronous to clk
//   sdram_cke   out 1       SDRAM clock enable
//   sdram_cmd   out 4       {cs_n, ras_n, cas_n, we_n}
//   sdram_addr  out ADDR_W  SDRAM address bus
//   sdram_ba    out BA_W    SDRAM bank address
//   init_done   out 1       high while initialized and bus released
// All outputs are registered.
// -----------------------------------------------------------------------------
module sdram_init_seq
    import sdram_pkg::*;
#(
    parameter int                T_POWERUP_CYC = DEF_T_POWERUP_CYC,
    parameter int                T_RP_CYC      = DEF_T_RP_CYC,
    parameter int                T_RFC_CYC     = DEF_T_RFC_CYC,
    parameter int                T_MRD_CYC     = DEF_T_MRD_CYC,
    parameter int                N_REFRESH     = DEF_N_REFRESH,
    parameter int                ADDR_W        = 13,
    parameter int                BA_W          = 2,
    parameter logic [ADDR_W-1:0] MODE_REG      = DEF_MODE_REG
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pll_lock,
    output logic              sdram_cke,
    output logic [3:0]        sdram_cmd,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [BA_W-1:0]   sdram_ba,
    output logic              init_done
);

    localparam int T_MAX = max_int(max_int(T_POWERUP_CYC, T_RP_CYC),
                                   max_int(T_RFC_CYC, T_MRD_CYC));
    localparam int CNT_W = $clog2(T_MAX + 1);
    localparam int REF_W = $clog2(N_REFRESH + 1);

    logic              lock_s;
    init_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [REF_W-1:0]  ref_q, ref_d;

    logic              cke_d;
    logic [3:0]        cmd_d;
    logic [ADDR_W-1:0] addr_d;
    logic [BA_W-1:0]   ba_d;
    logic              done_d;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    // Wait states hold for T_x_CYC-1 cycles after their 1-cycle command, so
    // the counter is loaded with T_x_CYC-2 and the exit happens on zero. The
    // counter only decrements while nonzero, so it can never wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ref_d   = ref_q;

        if (state_q != ST_WAIT_LOCK && !lock_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = ST_POWERUP;
                        cnt_d   = CNT_W'(T_POWERUP_CYC - 1);
                    end
                end
                ST_POWERUP: begin
                    if (cnt_q == '0) begin
                        state_d = ST_PRECHARGE;
                        ref_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_PRECHARGE: begin
                    state_d = ST_WAIT_RP;
                    cnt_d   = CNT_W'(T_RP_CYC - 2);
                end
                ST_WAIT_RP: begin
                    if (cnt_q == '0) begin
                        state_d = ST_REFRESH;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_REFRESH: begin
                    state_d = ST_WAIT_RFC;
                    cnt_d   = CNT_W'(T_RFC_CYC - 2);
                    ref_d   = ref_q + REF_W'(1);
                end
                ST_WAIT_RFC: begin
                    if (cnt_q == '0) begin
                        // ref_q already counts the refresh just issued
                        if (ref_q < REF_W'(N_REFRESH)) begin
                            state_d = ST_REFRESH;
                        end else begin
                            state_d = ST_LOAD_MODE;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_LOAD_MODE: begin
                    state_d = ST_WAIT_MRD;
                    cnt_d   = CNT_W'(T_MRD_CYC - 2);
                end
                ST_WAIT_MRD: begin
                    if (cnt_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so the bus
    // shows the command of a state in exactly the cycle that state is active.
    always_comb begin
        cke_d  = 1'b1;
        cmd_d  = CMD_NOP;
        addr_d = '0;
        ba_d   = '0;
        done_d = 1'b0;

        unique case (state_d)
            ST_WAIT_LOCK: begin
                cke_d = 1'b0;
                cmd_d = CMD_INHIBIT;
            end
            ST_PRECHARGE: begin
                cmd_d      = CMD_PRECHARGE;
                addr_d[10] = 1'b1;           // A10 high selects all banks
            end
            ST_REFRESH: begin
                cmd_d = CMD_REFRESH;
            end
            ST_LOAD_MODE: begin
                cmd_d  = CMD_LMR;
                addr_d = MODE_REG;
            end
            ST_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                cmd_d = CMD_NOP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_WAIT_LOCK;
            cnt_q      <= '0;
            ref_q      <= '0;
            sdram_cke  <= 1'b0;
            sdram_cmd  <= CMD_INHIBIT;
            sdram_addr <= '0;
            sdram_ba   <= '0;
            init_done  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ref_q      <= ref_d;
            sdram_cke  <= cke_d;
            sdram_cmd  <= cmd_d;
            sdram_addr <= addr_d;
            sdram_ba   <= ba_d;
            init_done  <= done_d;
        end
    end

endmodule

// File: tb/tb_sdram_init_seq.sv
// -----------------------------------------------------------------------------
// tb_sdram_init_seq
// Self-checking bench for sdram_init_seq with shortened power-up timing.
// Each lock-raise pushes the expected command timeline (absolute cycle, cmd,
// addr) into a scoreboard queue; a negedge monitor pops one entry for every
// real command the DUT drives and compares it.
// -----------------------------------------------------------------------------
module tb_sdram_init_seq;

    localparam int          TPU  = 20;
    localparam int          TRP  = 3;
    localparam int          TRFC = 9;
    localparam int          TMRD = 2;
    localparam int          NREF = 8;
    localparam logic [12:0] MODE = 13'h0032;

    localparam logic [3:0] C_INH = 4'b1111;
    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_LMR = 4'b0000;

    localparam int DONE_OFS = TPU + TRP + (NREF - 1) * TRFC + TRFC + TMRD; // 97

    logic        clk;
    logic        rst_n;
    logic        pll_lock;
    logic        sdram_cke;
    logic [3:0]  sdram_cmd;
    logic [12:0] sdram_addr;
    logic [1:0]  sdram_ba;
    logic        init_done;

    int errors;
    int checks;
    int cyc;

    typedef struct {
        int          cyc;
        logic [3:0]  cmd;
        logic [12:0] addr;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    sdram_init_seq #(
        .T_POWERUP_CYC (TPU),
        .T_RP_CYC      (TRP),
        .T_RFC_CYC     (TRFC),
        .T_MRD_CYC     (TMRD),
        .N_REFRESH     (NREF),
        .ADDR_W        (13),
        .BA_W          (2),
        .MODE_REG      (MODE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_lock   (pll_lock),
        .sdram_cke  (sdram_cke),
        .sdram_cmd  (sdram_cmd),
        .sdram_addr (sdram_addr),
        .sdram_ba   (sdram_ba),
        .init_done  (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Command monitor / scoreboard and CKE/init_done protocol rules
    always @(negedge clk) begin
        if (sdram_cmd != C_NOP && sdram_cmd != C_INH) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_cmd: cyc=%0d cmd=%b addr=%h, required no command",
                         cyc, sdram_cmd, sdram_addr);
            end else begin
                mon_e = sb.pop_front();
                if (cyc !== mon_e.cyc || sdram_cmd !== mon_e.cmd ||
                    sdram_addr !== mon_e.addr || sdram_ba !== 2'b00) begin
                    errors++;
                    $display("FAIL cmd_timeline: got cyc=%0d cmd=%b addr=%h ba=%b, required cyc=%0d cmd=%b addr=%h ba=00",
                             cyc, sdram_cmd, sdram_addr, sdram_ba,
                             mon_e.cyc, mon_e.cmd, mon_e.addr);
                end
            end
        end
        if (!sdram_cke) begin
            checks++;
            if (sdram_cmd !== C_INH || init_done !== 1'b0) begin
                errors++;
                $display("FAIL cke_low_proto: cyc=%0d cmd=%b done=%b, required cmd=1111 done=0",
                         cyc, sdram_cmd, init_done);
            end
        end
        if (init_done) begin
            checks++;
            if (sdram_cmd !== C_NOP || sdram_cke !== 1'b1) begin
                errors++;
                $display("FAIL done_proto: cyc=%0d cmd=%b cke=%b, required cmd=0111 cke=1",
                         cyc, sdram_cmd, sdram_cke);
            end
        end
    end

    // Push the expected commands of one init sequence whose CKE rise is at
    // absolute cycle base, keeping only those at relative cycle <= cutoff.
    task automatic push_seq(input int base, input int cutoff);
        exp_t e;
        int   rel;
        rel = TPU;
        if (rel <= cutoff) begin
            e.cyc = base + rel; e.cmd = C_PRE; e.addr = 13'h0400; sb.push_back(e);
        end
        rel = rel + TRP;
        for (int i = 0; i < NREF; i++) begin
            if (rel <= cutoff) begin
                e.cyc = base + rel; e.cmd = C_REF; e.addr = 13'h0000; sb.push_back(e);
            end
            rel = rel + TRFC;
        end
        if (rel <= cutoff) begin
            e.cyc = base + rel; e.cmd = C_LMR; e.addr = MODE; sb.push_back(e);
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        pll_lock = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (sdram_cke !== 1'b0 || sdram_cmd !== C_INH || sdram_addr !== 13'h0 ||
            sdram_ba !== 2'b00 || init_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: cke=%b cmd=%b addr=%h ba=%b done=%b, required 0 1111 0000 00 0",
                     sdram_cke, sdram_cmd, sdram_addr, sdram_ba, init_done);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checks++;
            if (sdram_cke !== 1'b0 || sdram_cmd !== C_INH || init_done !== 1'b0) begin
                errors++;
                $display("FAIL idle_no_lock: cyc=%0d cke=%b cmd=%b done=%b, required 0 1111 0",
                         cyc, sdram_cke, sdram_cmd, init_done);
            end
        end
    endtask

    // Raise lock at a negedge and return the absolute cycle CKE must rise at
    task automatic raise_lock(output int base, input int cutoff);
        pll_lock = 1'b1;
        base = cyc + 3;
        push_seq(base, cutoff);
    endtask

    task automatic test_full_sequence();
        int base;
        raise_lock(base, 1000);
        wait_cyc(base - 1);
        checks++;
        if (sdram_cke !== 1'b0) begin
            errors++;
            $display("FAIL cke_early: cyc=%0d cke=%b, required 0", cyc, sdram_cke);
        end
        wait_cyc(base);
        checks++;
        if (sdram_cke !== 1'b1 || sdram_cmd !== C_NOP) begin
            errors++;
            $display("FAIL cke_rise: cyc=%0d cke=%b cmd=%b, required 1 0111", cyc, sdram_cke, sdram_cmd);
        end
        wait_cyc(base + DONE_OFS - 1);
        checks++;
        if (init_done !== 1'b0) begin
            errors++;
            $display("FAIL done_early: rel=%0d done=%b, required 0", DONE_OFS - 1, init_done);
        end
        wait_cyc(base + DONE_OFS);
        for (int i = 0; i < 1000; i++) begin
            checks++;
            if (init_done !== 1'b1) begin
                errors++;
                $display("FAIL done_hold: rel=%0d done=%b, required 1", DONE_OFS + i, init_done);
            end
            @(negedge clk);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL full_seq_drain: %0d commands missing, required 0", sb.size());
        end
    endtask

    task automatic test_lock_loss_after_done();
        int m;
        int base;
        m = cyc;
        pll_lock = 1'b0;
        wait_cyc(m + 2);
        checks++;
        if (init_done !== 1'b1 || sdram_cke !== 1'b1) begin
            errors++;
            $display("FAIL loss_too_early: done=%b cke=%b, required 1 1", init_done, sdram_cke);
        end
        wait_cyc(m + 3);
        checks++;
        if (init_done !== 1'b0 || sdram_cke !== 1'b0 || sdram_cmd !== C_INH) begin
            errors++;
            $display("FAIL loss_after_done: done=%b cke=%b cmd=%b, required 0 0 1111",
                     init_done, sdram_cke, sdram_cmd);
        end
        repeat (10) @(negedge clk);
        raise_lock(base, 1000);
        wait_cyc(base + DONE_OFS - 1);
        checks++;
        if (init_done !== 1'b0) begin
            errors++;
            $display("FAIL relock_done_early: done=%b, required 0", init_done);
        end
        wait_cyc(base + DONE_OFS);
        checks++;
        if (init_done !== 1'b1) begin
            errors++;
            $display("FAIL relock_done: done=%b, required 1", init_done);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL relock_drain: %0d commands missing, required 0", sb.size());
        end
    endtask

    task automatic test_abort_mid_refresh();
        int base;
        pll_lock = 1'b0;
        repeat (10) @(negedge clk);
        // commands up to relative cycle 52 are on the bus before the abort lands
        raise_lock(base, 52);
        wait_cyc(base + 50);
        pll_lock = 1'b0;
        wait_cyc(base + 52);
        checks++;
        if (sdram_cke !== 1'b1) begin
            errors++;
            $display("FAIL abort_too_early: cke=%b, required 1", sdram_cke);
        end
        wait_cyc(base + 53);
        checks++;
        if (sdram_cke !== 1'b0 || sdram_cmd !== C_INH || init_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_outputs: cke=%b cmd=%b done=%b, required 0 1111 0",
                     sdram_cke, sdram_cmd, init_done);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL abort_drain: %0d commands missing, required 0", sb.size());
        end
        repeat (5) @(negedge clk);
        raise_lock(base, 1000);
        wait_cyc(base + DONE_OFS);
        checks++;
        if (init_done !== 1'b1 || sb.size() != 0) begin
            errors++;
            $display("FAIL abort_restart: done=%b pending=%0d, required 1 0", init_done, sb.size());
        end
    endtask

    task automatic test_async_reset();
        int base;
        int n;
        pll_lock = 1'b0;
        repeat (10) @(negedge clk);
        raise_lock(base, 60);
        wait_cyc(base + 60);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (sdram_cke !== 1'b0 || sdram_cmd !== C_INH || sdram_addr !== 13'h0 ||
            sdram_ba !== 2'b00 || init_done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: cke=%b cmd=%b addr=%h ba=%b done=%b, required 0 1111 0000 00 0",
                     sdram_cke, sdram_cmd, sdram_addr, sdram_ba, init_done);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL async_reset_drain: %0d commands missing, required 0", sb.size());
        end
        repeat (2) @(negedge clk);
        // lock is still high: releasing reset behaves like a fresh lock rise
        n = cyc;
        rst_n = 1'b1;
        base = n + 3;
        push_seq(base, 1000);
        wait_cyc(base - 1);
        checks++;
        if (sdram_cke !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_cke_early: cke=%b, required 0", sdram_cke);
        end
        wait_cyc(base);
        checks++;
        if (sdram_cke !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_cke: cke=%b, required 1", sdram_cke);
        end
        wait_cyc(base + DONE_OFS);
        checks++;
        if (init_done !== 1'b1 || sb.size() != 0) begin
            errors++;
            $display("FAIL post_reset_done: done=%b pending=%0d, required 1 0", init_done, sb.size());
        end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        rst_n    = 1'b0;
        pll_lock = 1'b0;
        @(negedge clk);
        test_reset();
        test_full_sequence();
        test_lock_loss_after_done();
        test_abort_mid_refresh();
        test_async_reset();
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
